fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 37 +++
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: ID-stage control/targets, instruction memory port and IF/ID buffer outputs.
// The master side is the surrounding pipeline or memory; the slave side is fetch_stage.
interface fetch_stage_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic               stall;
  logic               killF;
  logic [1:0]         PCSrc;
  logic               PCsrcJType;
  logic               RRSrc;
  logic [PC_W-1:0]    branchTarget;
  logic [PC_W-1:0]    forTarget;
  logic [PC_W-1:0]    jumpTarget;
  logic [PC_W-1:0]    retAddr;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] IDInstr;
  logic [PC_W-1:0]    IDPC;
  logic [PC_W-1:0]    IDPCPlus1;
  logic               IDValid;
  logic               ras_err;

  modport master (
    output stall, killF, PCSrc, PCsrcJType, RRSrc,
    output branchTarget, forTarget, jumpTarget, retAddr,
    output imem_rdata,
    input  imem_addr, IDInstr, IDPC, IDPCPlus1, IDValid, ras_err
  );

  modport slave (
    input  stall, killF, PCSrc, PCsrcJType, RRSrc,
    input  branchTarget, forTarget, jumpTarget, retAddr,
    input  imem_rdata,
    output imem_addr, IDInstr, IDPC, IDPCPlus1, IDValid, ras_err
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID pipeline buffer.
// Define FETCH_STAGE_RAS_EN to add an internal circular return-address stack.
module fetch_stage #(
  parameter int                  PC_W      = 16,
  parameter int                  INSTR_W   = 16,
  parameter logic [PC_W-1:0]     RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = 16'hF000,
  parameter int                  RAS_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  fetch_stage_if.slave bus
);

  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_FOR    = 2'b10;
  localparam logic [1:0] SRC_JTYPE  = 2'b11;

  logic [PC_W-1:0]    pc_r;
  logic [PC_W-1:0]    pc_plus1_s;
  logic [PC_W-1:0]    ret_addr_s;
  logic [PC_W-1:0]    next_pc_s;
  logic [INSTR_W-1:0] id_instr_r;
  logic [PC_W-1:0]    id_pc_r;
  logic [PC_W-1:0]    id_pc_plus1_r;
  logic               id_valid_r;

  assign pc_plus1_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};

`ifdef FETCH_STAGE_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  ras_mem_r [RAS_DEPTH];
  logic [PTR_W-1:0] sp_r;
  logic [PTR_W-1:0] sp_next_s;
  logic [PTR_W-1:0] sp_inc_s;
  logic [PTR_W-1:0] sp_dec_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             ras_empty_s;
  logic             ras_full_s;
  logic             do_push_s;
  logic             do_pop_s;
  logic             wr_en_s;
  logic [PTR_W-1:0] wr_idx_s;
  logic             err_next_s;
  logic             ras_err_r;

  assign do_push_s = !bus.stall && bus.RRSrc;
  assign do_pop_s  = !bus.stall && (bus.PCSrc == SRC_JTYPE) && bus.PCsrcJType;

  // sp_r points at the next free slot; a full push overwrites the oldest entry in place.
  always_comb begin
    sp_inc_s    = (sp_r == PTR_W'(RAS_DEPTH - 1)) ? {PTR_W{1'b0}} : sp_r + PTR_W'(1);
    sp_dec_s    = (sp_r == {PTR_W{1'b0}}) ? PTR_W'(RAS_DEPTH - 1) : sp_r - PTR_W'(1);
    ras_empty_s = (cnt_r == {CNT_W{1'b0}});
    ras_full_s  = (cnt_r == CNT_W'(RAS_DEPTH));
    ret_addr_s  = ras_empty_s ? RESET_PC : ras_mem_r[sp_dec_s];
    sp_next_s   = sp_r;
    cnt_next_s  = cnt_r;
    wr_en_s     = 1'b0;
    wr_idx_s    = sp_r;
    err_next_s  = 1'b0;
    if (do_pop_s && do_push_s) begin
      if (ras_empty_s) begin
        err_next_s = 1'b1;
        wr_en_s    = 1'b1;
        wr_idx_s   = sp_r;
        sp_next_s  = sp_inc_s;
        cnt_next_s = cnt_r + CNT_W'(1);
      end else begin
        wr_en_s  = 1'b1;
        wr_idx_s = sp_dec_s;
      end
    end else if (do_pop_s) begin
      if (ras_empty_s) begin
        err_next_s = 1'b1;
      end else begin
        sp_next_s  = sp_dec_s;
        cnt_next_s = cnt_r - CNT_W'(1);
      end
    end else if (do_push_s) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = sp_r;
      sp_next_s = sp_inc_s;
      if (ras_full_s) begin
        err_next_s = 1'b1;
      end else begin
        cnt_next_s = cnt_r + CNT_W'(1);
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Return-address stack storage, pointer, occupancy and error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= {PC_W{1'b0}};
      end
      sp_r      <= {PTR_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      ras_err_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        ras_mem_r[wr_idx_s] <= id_pc_plus1_r;
      end
      sp_r      <= sp_next_s;
      cnt_r     <= cnt_next_s;
      ras_err_r <= err_next_s;
    end
  end

  assign bus.ras_err = ras_err_r;
`else
  assign ret_addr_s  = bus.retAddr;
  assign bus.ras_err = 1'b0;
`endif

  // Next-PC selection.
  always_comb begin
    next_pc_s = pc_plus1_s;
    case (bus.PCSrc)
      SRC_SEQ:    next_pc_s = pc_plus1_s;
      SRC_BRANCH: next_pc_s = bus.branchTarget;
      SRC_FOR:    next_pc_s = bus.forTarget;
      SRC_JTYPE:  next_pc_s = bus.PCsrcJType ? ret_addr_s : bus.jumpTarget;
      default:    next_pc_s = pc_plus1_s;
    endcase
  end

  // PC and IF/ID buffer; stall freezes both, kill inserts a bubble but keeps the old PC tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r          <= RESET_PC;
      id_instr_r    <= NOP_INSTR;
      id_pc_r       <= {PC_W{1'b0}};
      id_pc_plus1_r <= {PC_W{1'b0}};
      id_valid_r    <= 1'b0;
    end else if (!bus.stall) begin
      pc_r <= next_pc_s;
      if (bus.killF) begin
        id_instr_r <= NOP_INSTR;
        id_valid_r <= 1'b0;
      end else begin
        id_instr_r    <= bus.imem_rdata;
        id_pc_r       <= pc_r;
        id_pc_plus1_r <= pc_plus1_s;
        id_valid_r    <= 1'b1;
      end
    end
  end

  assign bus.imem_addr = pc_r;
  assign bus.IDInstr   = id_instr_r;
  assign bus.IDPC      = id_pc_r;
  assign bus.IDPCPlus1 = id_pc_plus1_r;
  assign bus.IDValid   = id_valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a reference model pushes expected state per cycle, checked after each edge.
// RAS scenarios run only when FETCH_STAGE_RAS_EN is defined.
module tb_fetch_stage;

  logic clk;
  logic reset;
  int   assert_cnt;
  int   fail_cnt;

  fetch_stage_if #(.PC_W(16), .INSTR_W(16)) bus ();

  fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    return {a[7:0] ^ 8'h5A, a[15:8] ^ a[7:0] ^ 8'hC3};
  endfunction

  always_comb bus.imem_rdata = mem_word(bus.imem_addr);

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] idpc;
    logic [15:0] idp1;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_pc, m_instr, m_idpc, m_idp1;
  logic        m_valid, m_err;
  logic [15:0] m_ras[$];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assert_cnt++;
    if (obs !== expv) begin
      fail_cnt++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 16'h0000;
    m_instr = 16'hF000;
    m_idpc  = 16'h0000;
    m_idp1  = 16'h0000;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_ras.delete();
    sb_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check_value({tag, "_pc"},    {16'h0000, bus.imem_addr}, 32'h0000_0000);
    check_value({tag, "_instr"}, {16'h0000, bus.IDInstr},   32'h0000_F000);
    check_value({tag, "_idpc"},  {16'h0000, bus.IDPC},      32'h0000_0000);
    check_value({tag, "_idp1"},  {16'h0000, bus.IDPCPlus1}, 32'h0000_0000);
    check_value({tag, "_valid"}, {31'd0, bus.IDValid},      32'd0);
    check_value({tag, "_err"},   {31'd0, bus.ras_err},      32'd0);
  endtask

  // Entered and left at a falling edge: drive, predict, clock, compare.
  task automatic step(input logic s, input logic k, input logic [1:0] src, input logic jt,
                      input logic rr, input logic [15:0] bt, input logic [15:0] ft,
                      input logic [15:0] jta, input logic [15:0] ra);
    logic [15:0] ret;
    logic [15:0] nxt;
    logic        err;
    exp_t        e;
    exp_t        got;
    bus.stall = s;  bus.killF = k;  bus.PCSrc = src;  bus.PCsrcJType = jt;  bus.RRSrc = rr;
    bus.branchTarget = bt;  bus.forTarget = ft;  bus.jumpTarget = jta;  bus.retAddr = ra;
    err = 1'b0;
    ret = ra;
    if (!s) begin
`ifdef FETCH_STAGE_RAS_EN
      if (src == 2'b11 && jt) begin
        if (m_ras.size() == 0) begin
          err = 1'b1;
          ret = 16'h0000;
        end else begin
          ret = m_ras.pop_back();
        end
      end
      if (rr) begin
        m_ras.push_back(m_idp1);
        if (m_ras.size() > 4) begin
          void'(m_ras.pop_front());
          err = 1'b1;
        end
      end
`endif
      case (src)
        2'b00:   nxt = m_pc + 16'h0001;
        2'b01:   nxt = bt;
        2'b10:   nxt = ft;
        default: nxt = jt ? ret : jta;
      endcase
      if (k) begin
        m_instr = 16'hF000;
        m_valid = 1'b0;
      end else begin
        m_instr = mem_word(m_pc);
        m_idpc  = m_pc;
        m_idp1  = m_pc + 16'h0001;
        m_valid = 1'b1;
      end
      m_pc = nxt;
    end
    m_err = err;
    e.pc = m_pc;  e.instr = m_instr;  e.idpc = m_idpc;  e.idp1 = m_idp1;
    e.valid = m_valid;  e.err = m_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_value("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check_value("pc",    {16'h0000, bus.imem_addr}, {16'h0000, got.pc});
      check_value("instr", {16'h0000, bus.IDInstr},   {16'h0000, got.instr});
      check_value("idpc",  {16'h0000, bus.IDPC},      {16'h0000, got.idpc});
      check_value("idp1",  {16'h0000, bus.IDPCPlus1}, {16'h0000, got.idp1});
      check_value("valid", {31'd0, bus.IDValid},      {31'd0, got.valid});
      check_value("err",   {31'd0, bus.ras_err},      {31'd0, got.err});
    end
    @(negedge clk);
  endtask

  task automatic nstep();
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
  endtask

  task automatic jump_to(input logic [15:0] t);
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, t, 16'h0000);
  endtask

  initial begin
    assert_cnt = 0;
    fail_cnt   = 0;
    reset = 1'b0;
    bus.stall = 1'b0;  bus.killF = 1'b0;  bus.PCSrc = 2'b00;  bus.PCsrcJType = 1'b0;
    bus.RRSrc = 1'b0;  bus.branchTarget = 16'h0000;  bus.forTarget = 16'h0000;
    bus.jumpTarget = 16'h0000;  bus.retAddr = 16'h0000;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Sequential fetch from reset, then branch with kill at PC=5.
    repeat (5) nstep();
    step(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, 16'h0000);
    nstep();
    // Stall+kill for two cycles at PC=7 holds everything, then resume.
    jump_to(16'h0007);
    step(1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 16'h0099, 16'h0088, 16'h0077, 16'h0066);
    step(1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 16'h0099, 16'h0088, 16'h0077, 16'h0066);
    nstep();
    nstep();
    // forTarget without kill, then wrap at 16'hFFFF.
    step(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 16'h0000, 16'h0300, 16'h0000, 16'h0000);
    jump_to(16'hFFFF);
    nstep();
    nstep();

`ifdef FETCH_STAGE_RAS_EN
    jump_to(16'h0010);
    nstep();
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0040, 16'h0000);
    nstep();
    step(1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    end
`else
    step(1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0555, 16'h0123);
    nstep();
`endif

    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end

    // Asynchronous reset mid-cycle during a pending redirect.
    bus.stall = 1'b0;  bus.killF = 1'b1;  bus.PCSrc = 2'b01;  bus.branchTarget = 16'h0777;
    #2 reset = 1'b1;
    #1;
    check_reset_state("async_rst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    nstep();
    nstep();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
